dest_reg_tracker: RTL

//  Successor to the E-stage destination mux. Selects the E-stage write register from RT, RD or the link

---
 rtl/dest_reg_tracker_pkg.sv | 12 +
 rtl/dest_pipe_stage.sv | 41 ++++
 rtl/dest_reg_tracker.sv | 113 +++++++++++
 3 files changed

// File: rtl/dest_reg_tracker_pkg.sv
// Shared encodings for the destination-register tracker: reg_dst_e select codes and
// the "no forward" select value.
package dest_reg_tracker_pkg;

    localparam logic [1:0] REG_DST_RT   = 2'b00;
    localparam logic [1:0] REG_DST_RD   = 2'b01;
    localparam logic [1:0] REG_DST_LINK = 2'b10;
    localparam logic [1:0] REG_DST_NONE = 2'b11;

    localparam int unsigned FWD_NONE = 0;

endpackage

// File: rtl/dest_pipe_stage.sv
// One post-E tracking stage: holds {valid,dest,we,isLoad}; loads on advance, or a bubble
// when advance and bubble are both set. Synchronous active-high reset.
module dest_pipe_stage #(
    parameter int unsigned REG_AW = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              advance,
    input  logic              bubble,
    input  logic              nextValid,
    input  logic [REG_AW-1:0] nextDest,
    input  logic              nextWe,
    input  logic              nextIsLoad,
    output logic              valid,
    output logic [REG_AW-1:0] dest,
    output logic              we,
    output logic              isLoad
);

    always_ff @(posedge clock) begin
        if (reset) begin
            valid  <= 1'b0;
            dest   <= '0;
            we     <= 1'b0;
            isLoad <= 1'b0;
        end else if (advance) begin
            if (bubble) begin
                valid  <= 1'b0;
                dest   <= '0;
                we     <= 1'b0;
                isLoad <= 1'b0;
            end else begin
                valid  <= nextValid;
                dest   <= nextDest;
                we     <= nextWe;
                isLoad <= nextIsLoad;
            end
        end
    end

endmodule

// File: rtl/dest_reg_tracker.sv
// E-stage destination select plus DEPTH-stage destination tracking with forwarding selects,
// load-use stall and final-stage writeback. DEST_TRACK_PERF_EN adds the stall_cnt counter.
module dest_reg_tracker
    import dest_reg_tracker_pkg::*;
#(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned LINK_REG = 31,
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned FWD_W    = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              advance,
    input  logic              flush_e,
    input  logic              valid_e,
    input  logic [1:0]        reg_dst_e,
    input  logic [REG_AW-1:0] rt_e,
    input  logic [REG_AW-1:0] rd_e,
    input  logic              reg_write_e,
    input  logic              mem_to_reg_e,
    input  logic [REG_AW-1:0] rs_e_src,
    input  logic [REG_AW-1:0] rt_e_src,
    input  logic [REG_AW-1:0] rs_d,
    input  logic [REG_AW-1:0] rt_d,
    output logic [REG_AW-1:0] write_reg_e,
    output logic [FWD_W-1:0]  fwd_a,
    output logic [FWD_W-1:0]  fwd_b,
    output logic              load_use_stall,
    output logic [REG_AW-1:0] write_reg_w,
    output logic              reg_write_w
`ifdef DEST_TRACK_PERF_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    logic weE;

    // Index 0 is the E-stage entry feeding stage 1; 1..DEPTH are the tracked stages.
    logic [DEPTH:0]    stValid;
    logic [DEPTH:0]    stWe;
    logic [DEPTH:0]    stIsLoad;
    logic [REG_AW-1:0] stDest [DEPTH+1];

    always_comb begin
        write_reg_e = '0;
        case (reg_dst_e)
            REG_DST_RT:   write_reg_e = rt_e;
            REG_DST_RD:   write_reg_e = rd_e;
            REG_DST_LINK: write_reg_e = REG_AW'(LINK_REG);
            default:      write_reg_e = '0;
        endcase
    end

    assign weE = valid_e & reg_write_e & (reg_dst_e != REG_DST_NONE) & (write_reg_e != '0);

    assign stValid[0]  = valid_e;
    assign stWe[0]     = weE;
    assign stIsLoad[0] = mem_to_reg_e;
    assign stDest[0]   = write_reg_e;

    for (genvar k = 1; k <= DEPTH; k++) begin : gStage
        dest_pipe_stage #(
            .REG_AW (REG_AW)
        ) uStage (
            .clock      (clock),
            .reset      (reset),
            .advance    (advance),
            .bubble     ((k == 1) ? flush_e : 1'b0),
            .nextValid  (stValid[k-1]),
            .nextDest   (stDest[k-1]),
            .nextWe     (stWe[k-1]),
            .nextIsLoad (stIsLoad[k-1]),
            .valid      (stValid[k]),
            .dest       (stDest[k]),
            .we         (stWe[k]),
            .isLoad     (stIsLoad[k])
        );
    end

    // Scan oldest to youngest so the youngest match wins; a load in stage 1 has no data yet.
    always_comb begin
        fwd_a = FWD_W'(FWD_NONE);
        fwd_b = FWD_W'(FWD_NONE);
        for (int k = DEPTH; k >= 1; k--) begin
            if (stValid[k] && stWe[k] && (stDest[k] != '0) && !(k == 1 && stIsLoad[k])) begin
                if (stDest[k] == rs_e_src) fwd_a = FWD_W'(k);
                if (stDest[k] == rt_e_src) fwd_b = FWD_W'(k);
            end
        end
    end

    assign load_use_stall = weE & mem_to_reg_e & ~flush_e &
                            ((write_reg_e == rs_d) | (write_reg_e == rt_d));

    assign write_reg_w = stDest[DEPTH];
    assign reg_write_w = stValid[DEPTH] & stWe[DEPTH];

`ifdef DEST_TRACK_PERF_EN
    logic [31:0] stallCnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            stallCnt <= '0;
        end else if (load_use_stall) begin
            stallCnt <= stallCnt + 32'd1;
        end
    end

    assign stall_cnt = stallCnt;
`endif

endmodule
